msgdma_fetch: RTL

//   Stream-to-local-logic adapter on the mSGDMA read side (memory-to-stream). Accepts Avalon-ST

---
 rtl/msgdma_fetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/msgdma_fetch.sv
// Avalon-ST sink adapter for the mSGDMA read side: checks sop/eop framing, buffers beats in a
// small FIFO and presents them to a local consumer over valid/ready.
module msgdma_fetch #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] source_data,
  input  logic         source_valid,
  output logic         source_ready,
  input  logic         source_startofpacket,
  input  logic         source_endofpacket,
  output logic [N-1:0] data,
  output logic         data_first,
  output logic         data_last,
  output logic         data_valid,
  input  logic         data_ready,
  output logic [15:0]  pkt_count,
  output logic         err_framing,
  input  logic         err_clear
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

  // Entry layout: {first, last, data}
  logic [N+1:0]   mem_q [DEPTH];
  logic [N+1:0]   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_q, ready_d;
  logic [15:0]    pkt_count_q, pkt_count_d;
  logic           err_q, err_d;
  state_t         state_q, state_d;

  logic           accept;
  logic           push;
  logic           pop;
  logic           pkt_inc;
  logic           err_set;
  logic           in_first;
  logic           in_last;
  logic           empty;
  logic [N+1:0]   head;

  assign accept = source_valid & ready_q;
  assign empty  = (count_q == '0);
  assign pop    = ~empty & data_ready;
  assign head   = mem_q[rd_ptr_q];

  // Framer: only accepted beats advance it; a stray continuation beat is dropped, a
  // premature sop restarts a packet in place.
  always_comb begin
    push     = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    pkt_inc  = 1'b0;
    err_set  = 1'b0;
    state_d  = state_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (source_startofpacket) begin
            push     = 1'b1;
            in_first = 1'b1;
            in_last  = source_endofpacket;
            if (source_endofpacket) pkt_inc = 1'b1;
            else                    state_d = IN_PKT;
          end else begin
            err_set = 1'b1;
          end
        end
        IN_PKT: begin
          push     = 1'b1;
          in_first = source_startofpacket;
          in_last  = source_endofpacket;
          err_set  = source_startofpacket;
          if (source_endofpacket) begin
            pkt_inc = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push && (wr_ptr_q == AW'(i))) mem_d[i] = {in_first, in_last, source_data};
    end
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    ready_d     = (count_d < CW'(DEPTH));
    pkt_count_d = pkt_count_q + 16'(pkt_inc);
    err_d       = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
      state_q     <= IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
      state_q     <= state_d;
    end
  end

  assign source_ready = ready_q;
  assign data_valid   = ~empty;
  assign data         = empty ? '0   : head[N-1:0];
  assign data_last    = empty ? 1'b0 : head[N];
  assign data_first   = empty ? 1'b0 : head[N+1];
  assign pkt_count    = pkt_count_q;
  assign err_framing  = err_q;

endmodule
